// File: rtl/clk_div_ctrl.sv
// Runtime controller for the fabric clock divider: holds the active ratio and defers
// ratio changes and stops to period boundaries so the registered divided clock never glitches.
module clk_div_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEFAULT_N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_n,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] cur_n,
    output logic [WIDTH-1:0] cnt,
    output logic             clk_out,
    output logic             clk_en,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] pend_n, pend_n_nx;
    logic [WIDTH-1:0] cur_n_nx, cnt_nx, cnt_wrap;
    logic             accept, cfg_ok, boundary;
    logic             clk_out_nx, clk_en_nx;

    // Handshake: a ratio is taken on any cycle where cfg_valid && cfg_ready; cfg_ready is
    // low only while a ratio is already waiting for the boundary.
    assign cfg_ready = (state != ST_PEND);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_ok    = accept && (cfg_n != '0);
    assign boundary  = (state != ST_STOP) && (cnt == cur_n - 1'b1);
    assign cnt_wrap  = boundary ? '0 : cnt + 1'b1;
    assign busy      = (state != ST_STOP);
    assign state_dbg = state;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_wrap;
        cur_n_nx  = cur_n;
        pend_n_nx = pend_n;
        case (state)
            ST_STOP: begin
                cnt_nx = '0;
                if (cfg_ok) cur_n_nx = cfg_n;
                if (enable) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_ok) begin
                    pend_n_nx = cfg_n;
                    state_nx  = ST_PEND;
                end else if (!enable) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_PEND: begin
                // Stop request is re-evaluated here so the new-ratio period always runs in full.
                if (boundary) begin
                    cur_n_nx = pend_n;
                    state_nx = enable ? ST_RUN : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cfg_ok) begin
                    pend_n_nx = cfg_n;
                    state_nx  = ST_PEND;
                end else if (enable) begin
                    state_nx = ST_RUN;
                end else if (boundary) begin
                    state_nx = ST_STOP;
                end
            end
            default: begin
                state_nx = ST_STOP;
                cnt_nx   = '0;
            end
        endcase
    end

    assign clk_out_nx = (state != ST_STOP) && (state_nx != ST_STOP) && (cnt >= (cur_n >> 1));
    assign clk_en_nx  = (state_nx != ST_STOP) && (cnt_nx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_STOP;
            cur_n   <= WIDTH'(DEFAULT_N);
            pend_n  <= '0;
            cnt     <= '0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nx;
            cur_n   <= cur_n_nx;
            pend_n  <= pend_n_nx;
            cnt     <= cnt_nx;
            clk_out <= clk_out_nx;
            clk_en  <= clk_en_nx;
            cfg_err <= accept && (cfg_n == '0);
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl: a period-level reference model pushes the expected
// outputs each cycle into a queue; an independent monitor pops and compares them.
module tb_clk_div_ctrl;

    localparam int WIDTH     = 8;
    localparam int DEFAULT_N = 5;
    localparam int OW        = 2 * WIDTH + 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [WIDTH-1:0] cfg_n = '0;
    logic             cfg_ready, cfg_err, clk_out, clk_en, busy;
    logic [WIDTH-1:0] cur_n, cnt;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_N(DEFAULT_N)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_n(cfg_n),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cur_n(cur_n), .cnt(cnt),
        .clk_out(clk_out), .clk_en(clk_en), .busy(busy), .state_dbg(state_dbg)
    );

    logic [OW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;

    // Reference model: divider as "running / stop requested / queued ratio" plus period position.
    bit m_run, m_stopping, m_clk, m_tick, m_err;
    int m_n, m_pos;
    int m_pend[$];
    bit mv_ready, mv_acc, mv_good, mv_end, mv_halt, mv_old_clk;
    int mv_d;

    function automatic logic [OW-1:0] model_vec();
        logic exp_ready;
        exp_ready = !m_run || (m_pend.size() == 0);
        return {exp_ready, m_err, WIDTH'(m_n), WIDTH'(m_pos), m_clk, m_tick, m_run};
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst) begin
            m_run = 0; m_stopping = 0; m_clk = 0; m_tick = 0; m_err = 0;
            m_n = DEFAULT_N; m_pos = 0;
            m_pend.delete();
        end else begin
            mv_d     = int'(cfg_n);
            mv_ready = !m_run || (m_pend.size() == 0);
            mv_acc   = cfg_valid && mv_ready;
            mv_good  = mv_acc && (mv_d != 0);
            m_err    = mv_acc && (mv_d == 0);
            if (!m_run) begin
                if (mv_good) m_n = mv_d;
                m_clk = 0;
                m_pos = 0;
                if (enable) begin
                    m_run = 1;
                    m_stopping = 0;
                end
            end else begin
                mv_end     = (m_pos == m_n - 1);
                mv_old_clk = (m_pos >= m_n / 2);
                mv_halt    = 0;
                if (m_pend.size() > 0) begin
                    if (mv_end) begin
                        m_n = m_pend.pop_front();
                        m_stopping = !enable;
                    end
                end else if (mv_good) begin
                    m_pend.push_back(mv_d);
                end else if (m_stopping) begin
                    if (enable) m_stopping = 0;
                    else if (mv_end) mv_halt = 1;
                end else if (!enable) begin
                    m_stopping = 1;
                end
                m_pos = mv_end ? 0 : m_pos + 1;
                m_clk = mv_halt ? 1'b0 : mv_old_clk;
                if (mv_halt) m_run = 0;
            end
            m_tick = m_run && (m_pos == 0);
        end
        exp_q.push_back(model_vec());
    end

    // Monitor: every cycle the DUT presents a full output vector; compare against the queue head.
    logic [OW-1:0] got, want;
    always @(posedge clk) begin
        #1;
        got = {cfg_ready, cfg_err, cur_n, cnt, clk_out, clk_en, busy};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow cycle=%0d: no expected entry for got=%h", cycle, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL outputs cycle=%0d st=%0d got{rdy=%b err=%b n=%0d cnt=%0d clko=%b en=%b busy=%b} required{rdy=%b err=%b n=%0d cnt=%0d clko=%b en=%b busy=%b}",
                         cycle, state_dbg,
                         got[OW-1], got[OW-2], got[OW-3 -: WIDTH], got[3 +: WIDTH], got[2], got[1], got[0],
                         want[OW-1], want[OW-2], want[OW-3 -: WIDTH], want[3 +: WIDTH], want[2], want[1], want[0]);
            end
        end
    end

    task automatic drive(input logic en, input logic v, input logic [WIDTH-1:0] d);
        @(negedge clk);
        enable    = en;
        cfg_valid = v;
        cfg_n     = d;
    endtask

    task automatic random_segment(input int cycles, input int p_toggle, input int p_cfg,
                                  input int n_max);
        logic en;
        logic [WIDTH-1:0] d;
        en = enable;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 99) < p_toggle) en = ~en;
            if ($urandom_range(0, 9) == 0) d = '0;
            else d = WIDTH'($urandom_range(1, n_max));
            drive(en, ($urandom_range(0, 99) < p_cfg), d);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Plain run at the default ratio, then the ratio-change, zero-ratio and stop corners.
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 8'd3);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 8'd2);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, '0);

        random_segment(400, 5, 10, 8);
        random_segment(400, 20, 30, 3);
        random_segment(400, 2, 5, 16);
        random_segment(300, 40, 50, 6);

        // Reset while a ratio is pending.
        drive(1'b1, 1'b1, 8'd7);
        drive(1'b1, 1'b1, 8'd200);
        drive(1'b1, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        random_segment(400, 10, 20, 10);
        drive(1'b0, 1'b0, '0);
        repeat (300) drive(1'b0, 1'b0, '0);

        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
